// File: rtl/int_sequencer.sv
// Interrupt/exception/RTI sequencer for the memory stage: stalls the front end, then
// drives stack push, vector fetch, stack pop and PC/flag reload over several cycles.
module int_sequencer #(
  parameter logic [15:0] INT_VEC_ADDR = 16'd2,
  parameter logic [15:0] EXC_VEC_BASE = 16'd4
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_int,
  input  logic [1:0]  i_changeEPC,
  input  logic        i_rti,
  input  logic        i_pipeEmpty,
  input  logic [31:0] i_memData,
  input  logic [3:0]  i_flags,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_override,
  output logic        o_isStack,
  output logic        o_isPushPc,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_en32,
  output logic [15:0] o_aluAddr,
  output logic [2:0]  o_spSelect,
  output logic        o_pcLoad,
  output logic [31:0] o_pcValue,
  output logic        o_flagsLoad,
  output logic [3:0]  o_flagsValue
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_PUSH, S_VEC_READ, S_JUMP, S_POP, S_RESTORE
  } state_t;

  localparam logic [2:0] SP_HOLD = 3'b000;
  localparam logic [2:0] SP_DEC  = 3'b001;
  localparam logic [2:0] SP_INC  = 3'b010;

  state_t      state;
  logic        int_pending;
  logic        int_prev;
  logic [1:0]  exc_code;
  logic        int_edge;
  logic [15:0] vec_off;
  logic        unused_flags;

  // Flags reach the stack through the memory stage's own datapath.
  assign unused_flags = ^i_flags;

  assign int_edge = i_int & ~int_prev;
  assign vec_off  = ({14'd0, exc_code} - 16'd1) << 1;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      int_pending <= 1'b0;
      int_prev    <= 1'b0;
      exc_code    <= 2'd0;
    end else begin
      int_prev <= i_int;
      // A fresh edge wins over the clear so an interrupt landing on JUMP is not lost.
      if (int_edge)
        int_pending <= 1'b1;
      else if (state == S_JUMP && exc_code == 2'd0)
        int_pending <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_changeEPC != 2'd0) begin
            exc_code <= i_changeEPC;
            state    <= S_VEC_READ;
          end else if (i_rti) begin
            state <= S_POP;
          end else if (int_pending) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_changeEPC != 2'd0) begin
            exc_code <= i_changeEPC;
            state    <= S_VEC_READ;
          end else if (i_pipeEmpty) begin
            state <= S_PUSH;
          end
        end
        S_PUSH: begin
          exc_code <= 2'd0;
          state    <= S_VEC_READ;
        end
        S_VEC_READ: state <= S_JUMP;
        S_JUMP: begin
          exc_code <= 2'd0;
          state    <= S_IDLE;
        end
        S_POP:     state <= S_RESTORE;
        S_RESTORE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so an in-flight SP change or PC load dies immediately.
  always_comb begin
    o_busy       = 1'b0;
    o_stall      = 1'b0;
    o_flush      = 1'b0;
    o_override   = 1'b0;
    o_isStack    = 1'b0;
    o_isPushPc   = 1'b0;
    o_memRead    = 1'b0;
    o_memWrite   = 1'b0;
    o_en32       = 1'b0;
    o_aluAddr    = 16'd0;
    o_spSelect   = SP_HOLD;
    o_pcLoad     = 1'b0;
    o_pcValue    = 32'd0;
    o_flagsLoad  = 1'b0;
    o_flagsValue = 4'd0;
    if (!i_reset) begin
      o_busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          o_flush = (i_changeEPC != 2'd0);
        end
        S_DRAIN: begin
          o_stall = 1'b1;
          o_flush = (i_changeEPC != 2'd0);
        end
        S_PUSH: begin
          o_stall    = 1'b1;
          o_override = 1'b1;
          o_isStack  = 1'b1;
          o_isPushPc = 1'b1;
          o_memWrite = 1'b1;
          o_en32     = 1'b1;
          o_spSelect = SP_DEC;
        end
        S_VEC_READ: begin
          o_stall    = 1'b1;
          o_override = 1'b1;
          o_memRead  = 1'b1;
          o_en32     = 1'b1;
          o_aluAddr  = (exc_code == 2'd0) ? INT_VEC_ADDR : EXC_VEC_BASE + vec_off;
        end
        S_JUMP: begin
          o_stall   = 1'b1;
          o_flush   = 1'b1;
          o_pcLoad  = 1'b1;
          o_pcValue = i_memData;
        end
        S_POP: begin
          o_stall    = 1'b1;
          o_override = 1'b1;
          o_isStack  = 1'b1;
          o_memRead  = 1'b1;
          o_en32     = 1'b1;
          o_spSelect = SP_INC;
        end
        S_RESTORE: begin
          o_stall      = 1'b1;
          o_flush      = 1'b1;
          o_pcLoad     = 1'b1;
          o_pcValue    = {4'b0, i_memData[27:0]};
          o_flagsLoad  = 1'b1;
          o_flagsValue = i_memData[31:28];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Multi-cycle controller for the memory stage that handles interrupt entry, exception vectoring and RTI return. It stalls the front end and temporarily takes over the memory-stage control lines and the stack-pointer select. It then sequences the stack push, vector fetch, stack pop and PC/flag reload. It sits beside the memory stage and drives its stack/data-memory controls, the stack-pointer unit and the fetch-stage PC mux.

## Interface
Parameters:
- INT_VEC_ADDR, 16'd2: data-memory word address of the 32-bit interrupt vector.
- EXC_VEC_BASE, 16'd4: base address of the exception vectors. The vector for code c (1..3) is at EXC_VEC_BASE + 2*(c-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_int  in  1  external interrupt request, level; rising edge is latched.
- i_changeEPC  in  2  exception code from the memory-stage exception detector; 0 = none.
- i_rti  in  1  RTI in memory stage, one-cycle pulse.
- i_pipeEmpty  in  1  no valid instructions in ID/EX/MEM.
- i_memData  in  32  data-memory read data, valid the cycle after a read.
- i_flags  in  4  current CCR flags (pushed with PC by the memory stage).
- o_busy  out  1  sequencer not IDLE.
- o_stall  out  1  freeze PC and IF/ID.
- o_flush  out  1  squash IF/ID, ID/EX, EX/MEM contents.
- o_override  out  1  memory stage uses the o_* controls below instead of pipeline controls.
- o_isStack, o_isPushPc, o_memRead, o_memWrite, o_en32  out  1 each  memory-stage control overrides.
- o_aluAddr  out  16  non-stack access address when o_override=1.
- o_spSelect  out  3  stack-pointer control: 000 hold, 001 decrement by 2, 010 increment by 2.
- o_pcLoad  out  1  load o_pcValue into PC.
- o_pcValue  out  32  new PC.
- o_flagsLoad  out  1  load o_flagsValue into CCR.
- o_flagsValue  out  4  restored flags.

## Operation
- Registered state: state, int_pending, int_prev (for edge detection), exc_code (2 bits).
- Interrupt edge: i_int=1 and int_prev=0 at a clock edge sets int_pending. int_pending is cleared only on JUMP from an interrupt. Edges while pending is set are merged.
- IDLE: all outputs 0. Priority on leaving IDLE is exception > RTI > interrupt.
  - i_changeEPC≠0: latch exc_code, o_flush=1 this cycle, go to VEC_READ.
  - else i_rti: go to POP.
  - else int_pending: go to DRAIN.
- DRAIN: o_stall=1. An exception here is handled as in IDLE; int_pending is kept. When i_pipeEmpty=1, go to PUSH.
- PUSH (1 cycle): stall, override, isStack, isPushPc, memWrite, en32 = 1; spSelect=001. The memory stage writes (PC+1)|flags<<28. Go to VEC_READ with exc_code=0.
- VEC_READ (1 cycle): stall, override, memRead, en32 = 1; isStack=0. o_aluAddr = INT_VEC_ADDR if exc_code=0, else EXC_VEC_BASE+2*(exc_code-1). Go to JUMP.
- JUMP (1 cycle): o_pcLoad=1, o_pcValue=i_memData, o_flush=1, o_stall=1. Clear int_pending if exc_code=0; clear exc_code. Go to IDLE.
- POP (1 cycle): stall, override, isStack, memRead, en32 = 1; spSelect=010. Go to RESTORE.
- RESTORE (1 cycle): o_pcLoad=1, o_pcValue={4'b0, i_memData[27:0]}, o_flagsLoad=1, o_flagsValue=i_memData[31:28], o_flush=1, o_stall=1. Go to IDLE.
- i_changeEPC and i_rti are ignored in PUSH, VEC_READ, JUMP, POP and RESTORE.
- An interrupt that arrives during any sequence stays pending and is taken from IDLE afterwards.
- Address arithmetic is 16-bit and wraps modulo 2^16.
- All outputs are decoded from registered state plus inputs; there are no latches.

## Timing
- Reset (asynchronous, immediate): state=IDLE, int_pending=0, int_prev=0, exc_code=0; every output 0.
- Reset asserted mid-sequence aborts immediately. No partial SP change is issued after reset asserts.
- Interrupt latency, with i_pipeEmpty already 1 and i_int rising before edge E0:
  - E0 sets int_pending.
  - E1 enters DRAIN.
  - E2 enters PUSH.
  - E3 enters VEC_READ.
  - E4 enters JUMP; o_pcLoad is high between E4 and E5.
  - E5 returns to IDLE.
- Exception: o_flush in the detection cycle; VEC_READ next cycle; JUMP the cycle after that (2 cycles to o_pcLoad).
- RTI: POP next cycle, RESTORE the cycle after (o_pcLoad 2 cycles after i_rti).
- o_spSelect is non-zero for exactly one cycle per PUSH or POP.
- DRAIN has no timeout; it holds as long as i_pipeEmpty=0.

## Test plan
- Reset mid-PUSH: all outputs go to 0 immediately. After release, state is IDLE and a new i_int edge restarts the sequence from DRAIN.
- Interrupt: i_int rises, i_pipeEmpty=1, i_flags=4'hA, memory[2..3]=32'h0000_0100. Required: PUSH with spSelect=001 and isPushPc=1 at E2; vector read at address 2 at E3; pcLoad with 32'h100 between E4 and E5.
- Drain wait: i_pipeEmpty held 0 for 3 cycles after DRAIN entry. Required: o_stall=1 throughout, no PUSH until i_pipeEmpty=1, then normal sequence.
- Exception priority: i_changeEPC=2 and i_rti=1 in the same IDLE cycle with int_pending=1. Required: flush; vector read at address 6; pcLoad = memory[6..7]. Then the RTI is dropped and the interrupt is taken afterwards.
- RTI: i_rti pulse with i_memData=32'hA000_0051 on the POP-read cycle. Required: spSelect=010 for one cycle; pcLoad with 32'h0000_0051; flagsLoad with 4'hA.
- Interrupt during RTI: i_int edge while in POP. Required: RESTORE completes, then DRAIN on the cycle after returning to IDLE.
